// File: rtl/clock_mode_ctrl.sv
// Mode controller for the digital clock: owns the hh:mm:ss timekeeper and alarm
// registers, arbitrates shared buttons between the time and alarm setters.
module clock_mode_ctrl #(
    parameter int RING_SECONDS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       set,
    input  logic       up,
    input  logic       down,
    input  logic       tick_1hz,
    input  logic [1:0] ts_state,
    input  logic       ts_propagate,
    input  logic [4:0] ts_hours,
    input  logic [5:0] ts_minutes,
    input  logic [1:0] as_state,
    input  logic       as_propagate,
    input  logic [4:0] as_hours,
    input  logic [5:0] as_minutes,
    output logic       ts_setEnable,
    output logic       as_setEnable,
    output logic       btn_set,
    output logic       btn_up,
    output logic       btn_down,
    output logic [1:0] mode,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [4:0] disp_hours,
    output logic [5:0] disp_minutes,
    output logic       alarm_armed,
    output logic       alarm_ring
);

    localparam logic [1:0] MODE_CLOCK     = 2'b00;
    localparam logic [1:0] MODE_TIME_SET  = 2'b01;
    localparam logic [1:0] MODE_ALARM_SET = 2'b10;
    localparam logic [5:0] RING_LAST      = 6'(RING_SECONDS - 1);

    logic       setter_idle;
    logic       mode_accept;
    logic [1:0] next_mode;
    logic       load_time;
    logic       load_alarm;
    logic       forward_btns;
    logic       clock_btns;
    logic       ring_clear;
    logic       alarm_hit;
    logic       sec_wrap;
    logic       min_wrap;
    logic [4:0] next_hours;
    logic [5:0] next_minutes;
    logic [5:0] next_seconds;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic [5:0] ring_count;

    // The unused encoding 11 counts as idle so a mode_btn can always recover it.
    always_comb begin
        setter_idle = 1'b1;
        next_mode   = MODE_CLOCK;
        case (mode)
            MODE_CLOCK: begin
                setter_idle = 1'b1;
                next_mode   = MODE_TIME_SET;
            end
            MODE_TIME_SET: begin
                setter_idle = (ts_state == 2'b00);
                next_mode   = MODE_ALARM_SET;
            end
            MODE_ALARM_SET: begin
                setter_idle = (as_state == 2'b00);
                next_mode   = MODE_CLOCK;
            end
            default: begin
                setter_idle = 1'b1;
                next_mode   = MODE_CLOCK;
            end
        endcase
    end

    assign mode_accept  = mode_btn && setter_idle;
    assign load_time    = ts_propagate && (mode == MODE_TIME_SET);
    assign load_alarm   = as_propagate && (mode == MODE_ALARM_SET);

    // An accepted mode change swallows any button pressed in the same cycle.
    assign forward_btns = (mode != MODE_CLOCK) && !mode_accept;
    assign clock_btns   = (mode == MODE_CLOCK) && !mode_accept;

    assign ts_setEnable = (mode == MODE_TIME_SET);
    assign as_setEnable = (mode == MODE_ALARM_SET);
    assign btn_set      = set  && forward_btns;
    assign btn_up       = up   && forward_btns;
    assign btn_down     = down && forward_btns;

    always_comb begin
        disp_hours   = hours;
        disp_minutes = minutes;
        if (mode == MODE_TIME_SET) begin
            disp_hours   = ts_hours;
            disp_minutes = ts_minutes;
        end else if (mode == MODE_ALARM_SET) begin
            disp_hours   = as_hours;
            disp_minutes = as_minutes;
        end
    end

    assign sec_wrap = (seconds == 6'd59);
    assign min_wrap = (minutes == 6'd59);

    always_comb begin
        next_seconds = sec_wrap ? 6'd0 : seconds + 6'd1;
        next_minutes = minutes;
        next_hours   = hours;
        if (sec_wrap) begin
            next_minutes = min_wrap ? 6'd0 : minutes + 6'd1;
            if (min_wrap) begin
                next_hours = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
            end
        end
    end

    // Only a real tick can start the ring; a loaded time never does.
    assign alarm_hit  = alarm_armed && tick_1hz && !load_time &&
                        (next_hours == alarm_hours) &&
                        (next_minutes == alarm_minutes) &&
                        (next_seconds == 6'd0);
    assign ring_clear = clock_btns && (set || down);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode <= MODE_CLOCK;
        end else if (load_time || load_alarm) begin
            mode <= MODE_CLOCK;
        end else if (mode_accept) begin
            mode <= next_mode;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hours   <= 5'd0;
            minutes <= 6'd0;
            seconds <= 6'd0;
        end else if (load_time) begin
            hours   <= ts_hours;
            minutes <= ts_minutes;
            seconds <= 6'd0;
        end else if (tick_1hz) begin
            hours   <= next_hours;
            minutes <= next_minutes;
            seconds <= next_seconds;
        end
    end

    // Down beats up when both are pressed in CLOCK mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_hours   <= 5'd0;
            alarm_minutes <= 6'd0;
            alarm_armed   <= 1'b0;
        end else if (load_alarm) begin
            alarm_hours   <= as_hours;
            alarm_minutes <= as_minutes;
            alarm_armed   <= 1'b1;
        end else if (clock_btns && down) begin
            alarm_armed <= 1'b0;
        end else if (clock_btns && up) begin
            alarm_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_ring <= 1'b0;
            ring_count <= 6'd0;
        end else if (ring_clear) begin
            alarm_ring <= 1'b0;
            ring_count <= 6'd0;
        end else if (alarm_hit) begin
            alarm_ring <= 1'b1;
            ring_count <= 6'd0;
        end else if (alarm_ring && tick_1hz) begin
            if (ring_count == RING_LAST) begin
                alarm_ring <= 1'b0;
                ring_count <= 6'd0;
            end else begin
                ring_count <= ring_count + 6'd1;
            end
        end
    end

endmodule
